serial_add_ctrl: RTL and testbench

Bit-serial addition controller that time-shares one instance of the team's 1-bit full adder `fa` (ports a, b, c, sum, carry) to add two WIDTH-bit operands LSB-first, one bit per clock. It latches operands on a start request, drives `fa` for WIDTH cycles while holding the carry in a flip-flop, then presents the WIDTH-bit sum and carry-out with a one-cycle done pulse. It sits between a requester (bench or sequencer) and the shared `fa` datapath and is the reference sequencer for multi-bit use of `fa`.

---
 rtl/serial_add_ctrl.sv | 130 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: time-shares one 1-bit full adder to add two
// WIDTH-bit operands LSB-first, one bit per clock, then pulses done.

module fa (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [WIDTH-1:0]  s_sh;
    logic              carry;
    logic [CW-1:0]     cnt;
    logic              fa_sum;
    logic              fa_carry;

    fa u_fa (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .c     (carry),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = start ? RUN : IDLE;
            RUN:     state_next = (cnt == LAST) ? DONE : RUN;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are pure state decode, so no input reaches them combinationally.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN: begin
                busy = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            s_sh    <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            sum_out <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a_in;
                        b_sh  <= b_in;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    s_sh  <= {fa_sum, s_sh[WIDTH-1:1]};
                    carry <= fa_carry;
                    cnt   <= cnt + CW'(1);
                    // Last bit: result is taken straight from the adder so it
                    // lands on the same edge that enters DONE.
                    if (cnt == LAST) begin
                        sum_out <= {fa_sum, s_sh[WIDTH-1:1]};
                        cout    <= fa_carry;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: transaction-level model checked every cycle on a
// WIDTH=8 and a WIDTH=2 instance, plus directed literal expectations.

module tb_serial_add_ctrl;
    localparam int W8 = 8;
    localparam int W2 = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          st8 = 1'b0, c8 = 1'b0;
    logic [W8-1:0] a8 = '0, b8 = '0;
    logic          busy8, done8, cout8;
    logic [W8-1:0] sum8;

    logic          st2 = 1'b0, c2 = 1'b0;
    logic [W2-1:0] a2 = '0, b2 = '0;
    logic          busy2, done2, cout2;
    logic [W2-1:0] sum2;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    int done_cnt8 = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W8)) u_dut8 (
        .clk(clk), .rst(rst), .start(st8), .a_in(a8), .b_in(b8), .cin(c8),
        .busy(busy8), .done(done8), .sum_out(sum8), .cout(cout8)
    );

    serial_add_ctrl #(.WIDTH(W2)) u_dut2 (
        .clk(clk), .rst(rst), .start(st2), .a_in(a2), .b_in(b2), .cin(c2),
        .busy(busy2), .done(done2), .sum_out(sum2), .cout(cout2)
    );

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase = edges since the accepting edge (0 = idle). The result is
    // the plain arithmetic sum, published after WIDTH edges; done for one cycle.
    int          m8_phase = 0;
    logic [W8:0] m8_full = '0;
    logic [W8-1:0] m8_sum = '0;
    logic        m8_cout = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m8_phase <= 0;
            m8_sum   <= '0;
            m8_cout  <= 1'b0;
        end else if (m8_phase == 0) begin
            if (st8) begin
                m8_phase <= 1;
                m8_full  <= {1'b0, a8} + {1'b0, b8} + (W8+1)'(c8);
            end
        end else if (m8_phase == W8) begin
            m8_sum   <= m8_full[W8-1:0];
            m8_cout  <= m8_full[W8];
            m8_phase <= W8 + 1;
        end else if (m8_phase == W8 + 1) begin
            m8_phase <= 0;
        end else begin
            m8_phase <= m8_phase + 1;
        end
        if (done8) done_cnt8 <= done_cnt8 + 1;
    end

    int          m2_phase = 0;
    logic [W2:0] m2_full = '0;
    logic [W2-1:0] m2_sum = '0;
    logic        m2_cout = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m2_phase <= 0;
            m2_sum   <= '0;
            m2_cout  <= 1'b0;
        end else if (m2_phase == 0) begin
            if (st2) begin
                m2_phase <= 1;
                m2_full  <= {1'b0, a2} + {1'b0, b2} + (W2+1)'(c2);
            end
        end else if (m2_phase == W2) begin
            m2_sum   <= m2_full[W2-1:0];
            m2_cout  <= m2_full[W2];
            m2_phase <= W2 + 1;
        end else if (m2_phase == W2 + 1) begin
            m2_phase <= 0;
        end else begin
            m2_phase <= m2_phase + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy8", 33'(busy8), 33'(m8_phase != 0));
            check("done8", 33'(done8), 33'(m8_phase == W8 + 1));
            check("sum8",  33'(sum8),  33'(m8_sum));
            check("cout8", 33'(cout8), 33'(m8_cout));
            check("busy2", 33'(busy2), 33'(m2_phase != 0));
            check("done2", 33'(done2), 33'(m2_phase == W2 + 1));
            check("sum2",  33'(sum2),  33'(m2_sum));
            check("cout2", 33'(cout2), 33'(m2_cout));
        end
    end

    // Launch one operation from idle; returns the result and the number of
    // negedge samples from the accepting edge until done is seen.
    task automatic op8(input logic [W8-1:0] a, input logic [W8-1:0] b, input logic c,
                       output logic [W8-1:0] s, output logic co, output int lat);
        @(negedge clk);
        st8 = 1'b1; a8 = a; b8 = b; c8 = c;
        @(posedge clk);
        @(negedge clk);
        st8 = 1'b0; a8 = $urandom; b8 = $urandom; c8 = 1'($urandom);
        lat = 1;
        while (!done8 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        if (!done8) check("op8_timeout", 33'(0), 33'(1));
        s = sum8; co = cout8;
        @(negedge clk);
    endtask

    task automatic op2(input logic [W2-1:0] a, input logic [W2-1:0] b, input logic c,
                       output logic [W2-1:0] s, output logic co, output int lat);
        @(negedge clk);
        st2 = 1'b1; a2 = a; b2 = b; c2 = c;
        @(posedge clk);
        @(negedge clk);
        st2 = 1'b0;
        lat = 1;
        while (!done2 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        if (!done2) check("op2_timeout", 33'(0), 33'(1));
        s = sum2; co = cout2;
        @(negedge clk);
    endtask

    initial begin
        logic [W8-1:0] s;
        logic          co;
        logic [W2-1:0] s2;
        logic          co2;
        int            lat;
        int            d0;
        int            prev;
        int            k;

        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 33'(busy8), 33'(0));
        check("rst_done", 33'(done8), 33'(0));
        check("rst_sum",  33'(sum8),  33'(8'h00));
        check("rst_cout", 33'(cout8), 33'(0));

        op8(8'h5A, 8'h3C, 1'b0, s, co, lat);
        check("5A+3C_sum", 33'(s), 33'(8'h96));
        check("5A+3C_cout", 33'(co), 33'(0));
        check("5A+3C_latency", 33'(lat), 33'(9));

        op8(8'hFF, 8'h01, 1'b0, s, co, lat);
        check("FF+01_sum", 33'(s), 33'(8'h00));
        check("FF+01_cout", 33'(co), 33'(1));

        op8(8'hFF, 8'hFF, 1'b1, s, co, lat);
        check("FF+FF+1_sum", 33'(s), 33'(8'hFF));
        check("FF+FF+1_cout", 33'(co), 33'(1));

        // start held with other operands through RUN and DONE is ignored
        d0 = done_cnt8;
        @(negedge clk);
        st8 = 1'b1; a8 = 8'h10; b8 = 8'h20; c8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h01;
        k = 0;
        while (!done8 && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("ignore_sum", 33'(sum8), 33'(8'h30));
        @(negedge clk);
        st8 = 1'b0;
        repeat (12) @(negedge clk);
        check("ignore_one_done", 33'(done_cnt8 - d0), 33'(1));
        check("ignore_sum_hold", 33'(sum8), 33'(8'h30));

        // reset on the 4th RUN edge discards the operation
        d0 = done_cnt8;
        @(negedge clk);
        st8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; c8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        st8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 33'(busy8), 33'(0));
        check("midrst_sum",  33'(sum8),  33'(8'h00));
        check("midrst_cout", 33'(cout8), 33'(0));
        repeat (10) @(negedge clk);
        check("midrst_no_done", 33'(done_cnt8 - d0), 33'(0));
        op8(8'h03, 8'h04, 1'b0, s, co, lat);
        check("03+04_sum", 33'(s), 33'(8'h07));
        check("03+04_cout", 33'(co), 33'(0));

        // back-to-back with start held high
        @(negedge clk);
        st8 = 1'b1; a8 = 8'h80; b8 = 8'h80; c8 = 1'b0;
        prev = -1;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (done8) begin
                check("held_sum", 33'(sum8), 33'(8'h00));
                check("held_cout", 33'(cout8), 33'(1));
                if (prev >= 0) check("held_period", 33'(i - prev), 33'(10));
                prev = i;
            end
        end
        st8 = 1'b0;
        repeat (12) @(negedge clk);

        // randomized per-cycle stimulus including occasional resets
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            st8 = 1'($urandom_range(0, 2) != 0);
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            c8  = 1'($urandom);
            rst = ($urandom_range(0, 39) == 0);
        end
        @(negedge clk);
        rst = 1'b0; st8 = 1'b0;
        repeat (12) @(negedge clk);

        // exhaustive at WIDTH=2
        for (int i = 0; i < 32; i++) begin
            logic [4:0]  v;
            logic [2:0]  full;
            v = 5'(i);
            full = {1'b0, v[1:0]} + {1'b0, v[3:2]} + 3'(v[4]);
            op2(v[1:0], v[3:2], v[4], s2, co2, lat);
            check("w2_exh", 33'({co2, s2}), 33'(full));
            if (i == 0) check("w2_latency", 33'(lat), 33'(3));
        end

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end
endmodule
